// File: rtl/key_entry_buffer.sv
// Keypad press debouncer feeding a 5-digit entry buffer.
// A completed 5-digit entry is handed off as a valid/ready guess.
module key_entry_buffer #(
  parameter int unsigned RELEASE_CYCLES = 400000,
  parameter int unsigned CONFIRM        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_in,
  input  logic        guess_ready,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic [19:0] entry_digits,
  output logic [2:0]  entry_count,
  output logic [19:0] guess,
  output logic        guess_valid,
  output logic        reject
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_CONF = 2'd1;
  localparam logic [1:0]  S_HELD = 2'd2;
  localparam logic [19:0] L_TMAX = 20'(RELEASE_CYCLES - 1);
  localparam logic [2:0]  L_CONF = 3'(CONFIRM);

  logic [1:0]  r_state, w_state;
  logic [3:0]  r_cand, w_cand;
  logic [2:0]  r_cnt, w_cnt;
  logic [19:0] r_timer, w_timer;
  logic        w_sight, w_match, w_expire, w_accept;
  logic        w_dig, w_bksp, w_clr, w_ent;

  logic        r_event, r_reject, r_gvalid;
  logic [3:0]  r_code;
  logic [19:0] r_digits, r_guess;
  logic [2:0]  r_count;

  assign w_sight  = key_in != 4'hF;
  assign w_match  = w_sight && (key_in == r_cand);
  assign w_expire = r_timer == L_TMAX;

  always_comb begin
    w_state  = r_state;
    w_cand   = r_cand;
    w_cnt    = r_cnt;
    w_timer  = r_timer + 20'd1;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer = '0;
        if (w_sight) begin
          w_cand   = key_in;
          w_cnt    = 3'd1;
          w_accept = (L_CONF == 3'd1);
          w_state  = w_accept ? S_HELD : S_CONF;
        end
      end
      S_CONF: begin
        if (w_sight) begin
          w_timer = '0;
          if (w_match) begin
            w_cnt = r_cnt + 3'd1;
            if (r_cnt + 3'd1 == L_CONF) begin
              w_accept = 1'b1;
              w_state  = S_HELD;
            end
          end else begin
            w_cand = key_in;
            w_cnt  = 3'd1;
          end
        end else if (w_expire) begin
          w_state = S_IDLE;
          w_timer = '0;
          w_cnt   = '0;
        end
      end
      S_HELD: begin
        // Other codes while held do not refresh the release timer
        if (w_match) begin
          w_timer = '0;
        end else if (w_expire) begin
          w_state = S_IDLE;
          w_timer = '0;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_timer = '0;
        w_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_dig  = 1'b0;
    w_bksp = 1'b0;
    w_clr  = 1'b0;
    w_ent  = 1'b0;
    unique case (1'b1)
      (key_in <= 4'd9):  w_dig  = 1'b1;
      (key_in == 4'hB):  w_bksp = 1'b1;
      (key_in == 4'hC):  w_clr  = 1'b1;
      (key_in == 4'hE):  w_ent  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state;
      r_cand  <= w_cand;
      r_cnt   <= w_cnt;
      r_timer <= w_timer;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event  <= 1'b0;
      r_reject <= 1'b0;
      r_gvalid <= 1'b0;
      r_code   <= '0;
      r_digits <= '0;
      r_guess  <= '0;
      r_count  <= '0;
    end else begin
      r_event  <= w_accept;
      r_reject <= 1'b0;
      if (r_gvalid && guess_ready) r_gvalid <= 1'b0;
      if (w_accept) begin
        r_code <= key_in;
        if (r_gvalid) begin
          r_reject <= 1'b1;
        end else if (w_dig) begin
          if (r_count == 3'd5) begin
            r_reject <= 1'b1;
          end else begin
            for (int i = 0; i < 5; i++)
              if (3'(i) == r_count) r_digits[4*i +: 4] <= key_in;
            r_count <= r_count + 3'd1;
          end
        end else if (w_bksp) begin
          if (r_count == 3'd0) begin
            r_reject <= 1'b1;
          end else begin
            for (int i = 0; i < 5; i++)
              if (3'(i) == r_count - 3'd1) r_digits[4*i +: 4] <= 4'h0;
            r_count <= r_count - 3'd1;
          end
        end else if (w_clr) begin
          r_digits <= '0;
          r_count  <= '0;
        end else if (w_ent) begin
          if (r_count == 3'd5) begin
            r_guess  <= r_digits;
            r_gvalid <= 1'b1;
            r_digits <= '0;
            r_count  <= '0;
          end else begin
            r_reject <= 1'b1;
          end
        end
      end
    end
  end

  assign key_event    = r_event;
  assign key_code     = r_code;
  assign entry_digits = r_digits;
  assign entry_count  = r_count;
  assign guess        = r_guess;
  assign guess_valid  = r_gvalid;
  assign reject       = r_reject;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: press-level reference model checked
// every cycle, plus literal expectations on directed sequences.
module tb_key_entry_buffer;

  localparam int REL  = 16;
  localparam int CONF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  key_in = 4'hF;
  logic        rdy = 1'b0;
  logic        key_event, guess_valid, reject;
  logic [3:0]  key_code;
  logic [19:0] entry_digits, guess;
  logic [2:0]  entry_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ev    = 0;
  int n_rej   = 0;
  int cyc     = 0;

  key_entry_buffer #(.RELEASE_CYCLES(REL), .CONFIRM(CONF)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .guess_ready(rdy),
    .key_event(key_event), .key_code(key_code),
    .entry_digits(entry_digits), .entry_count(entry_count),
    .guess(guess), .guess_valid(guess_valid), .reject(reject)
  );

  always #5 clk = ~clk;

  // Reference model: tracked code, sighting streak, quiet-cycle run
  int         trk, streak, quiet, m_cnt, m_nev;
  bit         latched;
  logic [3:0] m_dig[5];
  logic [3:0] m_gd[5];
  logic [3:0] m_code;
  logic       m_ev, m_rej, m_gv;

  function automatic logic [19:0] pack(input logic [3:0] d[5]);
    logic [19:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) v[4*i +: 4] = d[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk = -1; streak = 0; quiet = 0; latched = 0;
      m_cnt = 0; m_code = 4'h0; m_ev = 0; m_rej = 0; m_gv = 0;
      for (int i = 0; i < 5; i++) begin m_dig[i] = 0; m_gd[i] = 0; end
    end else begin
      bit acc, clr, sight;
      logic [3:0] k;
      k = key_in;
      sight = (k != 4'hF);
      acc = 0;
      clr = m_gv && rdy;
      if (trk < 0) begin
        if (sight) begin
          trk = int'(k); streak = 1; quiet = 0;
          if (streak >= CONF) begin acc = 1; latched = 1; end
        end
      end else if (!latched) begin
        if (sight) begin
          if (int'(k) == trk) streak++;
          else begin trk = int'(k); streak = 1; end
          quiet = 0;
          if (streak == CONF) begin acc = 1; latched = 1; end
        end else begin
          quiet++;
          if (quiet == REL) trk = -1;
        end
      end else begin
        if (sight && int'(k) == trk) quiet = 0;
        else begin
          quiet++;
          if (quiet == REL) begin trk = -1; latched = 0; end
        end
      end
      m_ev = acc;
      m_rej = 0;
      if (acc) begin
        m_nev++;
        m_code = k;
        if (m_gv) m_rej = 1;
        else if (k <= 4'd9) begin
          if (m_cnt == 5) m_rej = 1;
          else begin m_dig[m_cnt] = k; m_cnt++; end
        end else if (k == 4'hB) begin
          if (m_cnt == 0) m_rej = 1;
          else begin m_cnt--; m_dig[m_cnt] = 0; end
        end else if (k == 4'hC) begin
          m_cnt = 0;
          for (int i = 0; i < 5; i++) m_dig[i] = 0;
        end else if (k == 4'hE) begin
          if (m_cnt == 5) begin
            for (int i = 0; i < 5; i++) begin m_gd[i] = m_dig[i]; m_dig[i] = 0; end
            m_gv = 1; m_cnt = 0;
          end else m_rej = 1;
        end
      end
      if (clr) m_gv = 0;
    end
  end

  function automatic logic [49:0] mvec();
    return {m_ev, m_code, pack(m_dig), 3'(m_cnt), pack(m_gd), m_gv, m_rej};
  endfunction

  always @(negedge clk) begin
    logic [49:0] dv;
    cyc++;
    dv = {key_event, key_code, entry_digits, entry_count, guess, guess_valid, reject};
    n_tests++;
    if (dv !== mvec()) begin
      n_fail++;
      $display("FAIL cycle%0d outputs dut=%h model=%h", cyc, dv, mvec());
    end
    if (key_event === 1'b1) n_ev++;
    if (reject === 1'b1) n_rej++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [3:0] k);
    @(negedge clk);
    key_in = k;
  endtask

  task automatic press(input logic [3:0] k);
    tick(k);
    tick(k);
    repeat (18) tick(4'hF);
  endtask

  int ev0, rj0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick(4'hF);
    chk("reset_outputs", 32'({key_event, key_code, entry_digits, entry_count}), 32'h0);
    chk("reset_guess", 32'({guess, guess_valid, reject}), 32'h0);
    rst_n = 1'b1;
    tick(4'hF);

    // Confirm after sparse sightings; re-sighting while held is silent
    tick(4'h3);
    repeat (7) tick(4'hF);
    tick(4'h3);
    tick(4'hF);
    chk("first_event", 32'(key_event), 32'h1);
    chk("first_code", 32'(key_code), 32'h3);
    chk("first_count", 32'(entry_count), 32'h1);
    chk("first_digits", 32'(entry_digits), 32'h00003);
    tick(4'hF); tick(4'hF); tick(4'h3); tick(4'hF);
    chk("held_no_event", 32'(key_event), 32'h0);
    repeat (20) tick(4'hF);

    // Lone sighting must never be accepted
    tick(4'h5);
    repeat (20) tick(4'hF);
    chk("lone_sighting", 32'(entry_count), 32'h1);

    ev0 = n_ev;
    press(4'h3);
    press(4'h3);
    chk("repress_events", 32'(n_ev - ev0), 32'd2);
    chk("model_events", 32'(m_nev), 32'd3);

    // Release boundary: 15 quiet cycles keep it held, 16 release it
    tick(4'h7); tick(4'h7);
    repeat (15) tick(4'hF);
    tick(4'h7);
    repeat (16) tick(4'hF);
    tick(4'h7); tick(4'h7);
    repeat (18) tick(4'hF);
    chk("boundary_count", 32'(entry_count), 32'd5);
    chk("boundary_digits", 32'(entry_digits), 32'h77333);
    press(4'hC);
    chk("clear_count", 32'(entry_count), 32'd0);

    // Candidate replacement in the confirm phase
    tick(4'h1); tick(4'h2); tick(4'h2);
    repeat (18) tick(4'hF);
    chk("replace_digits", 32'(entry_digits), 32'h00002);
    press(4'hC);

    rj0 = n_rej;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    press(4'h6);
    chk("full_reject", 32'(n_rej - rj0), 32'd1);
    chk("full_digits", 32'(entry_digits), 32'h54321);
    press(4'hE);
    chk("guess_value", 32'(guess), 32'h54321);
    chk("guess_valid", 32'(guess_valid), 32'h1);
    chk("enter_count", 32'(entry_count), 32'd0);

    rj0 = n_rej;
    press(4'h7);
    chk("pending_reject", 32'(n_rej - rj0), 32'd1);
    chk("pending_count", 32'(entry_count), 32'd0);
    chk("pending_valid", 32'(guess_valid), 32'h1);
    rdy = 1'b1;
    tick(4'hF);
    rdy = 1'b0;
    chk("handshake_clear", 32'(guess_valid), 32'h0);
    chk("guess_kept", 32'(guess), 32'h54321);
    tick(4'hF);

    rj0 = n_rej;
    press(4'h9); press(4'h8);
    chk("two_digits", 32'(entry_digits), 32'h00089);
    press(4'hB);
    chk("bksp1_count", 32'(entry_count), 32'd1);
    chk("bksp1_digits", 32'(entry_digits), 32'h00009);
    press(4'hB);
    chk("bksp2_count", 32'(entry_count), 32'd0);
    press(4'hB);
    press(4'hE);
    chk("empty_rejects", 32'(n_rej - rj0), 32'd2);

    ev0 = n_ev;
    press(4'h4); press(4'hA); press(4'hD);
    chk("ad_events", 32'(n_ev - ev0), 32'd3);
    chk("ad_digits", 32'(entry_digits), 32'h00004);
    press(4'hC);

    // Asynchronous reset mid-confirm with a guess pending
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    press(4'hE);
    chk("pre_reset_valid", 32'(guess_valid), 32'h1);
    tick(4'h4);
    tick(4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", 32'({key_event, key_code, entry_digits, entry_count}), 32'h0);
    chk("async_rst_b", 32'({guess, guess_valid, reject}), 32'h0);
    tick(4'hF); tick(4'hF);
    rst_n = 1'b1;
    press(4'h6);
    chk("post_rst_digits", 32'(entry_digits), 32'h00006);
    chk("post_rst_code", 32'(key_code), 32'h6);
    chk("post_rst_count", 32'(entry_count), 32'd1);

    tick(4'hF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
